// File: rtl/vbsme_test_pkg.sv
// Shared types for the VBSME result sequencer.
//   seq_state_t : sequencer FSM states
//   result_t    : one core result / expected record {x, y, sad}
//   DEF_DATA_W  : default (and maximum) width of the result fields
//   DEF_CNT_W   : default width of the trial index and tallies
package vbsme_test_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        RST_CORE,
        WAIT_RES,
        COMPARE,
        NEXT,
        DONE
    } seq_state_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] x;
        logic [DEF_DATA_W-1:0] y;
        logic [DEF_DATA_W-1:0] sad;
    } result_t;

endpackage

// File: rtl/vbsme_cycle_timer.sv
// Down-counting cycle timer. Loading N-1 makes expired rise after N cycles.
//   clk      in  clock
//   reset    in  synchronous active-high reset (count cleared, expired high)
//   load     in  load load_val this cycle
//   load_val in  W bits, value loaded
//   expired  out count has reached zero
module vbsme_cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/vbsme_result_sequencer.sv
// Self-checking trial sequencer for the VBSME motion-estimation core.
// Runs NUM_TESTS trials: resets the core, waits for its result strobe,
// compares the result with the expected table entry and tallies pass/fail.
// Optional watchdog: define VBSME_TIMEOUT_EN to fail trials whose result
// does not arrive within TIMEOUT_CYC cycles; otherwise timeout is tied low.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   start                   one-cycle run request (IDLE/DONE only)
//   core_rst                reset to the core (held high while idle/done)
//   res_valid, x_sad,
//   y_sad, sad              core result strobe and fields
//   test_idx                trial index, addresses the expected table
//   exp_x, exp_y, exp_sad   expected values for test_idx (combinational)
//   busy, done              run status
//   last_match              outcome of the latest trial
//   pass_cnt, fail_cnt      saturating tallies
//   timeout                 sticky watchdog flag
// DATA_W must not exceed the package result width.
module vbsme_result_sequencer
    import vbsme_test_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int NUM_TESTS   = 4,
    parameter int RST_CYC     = 2,
    parameter int TIMEOUT_CYC = 65536,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              core_rst,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] x_sad,
    input  logic [DATA_W-1:0] y_sad,
    input  logic [DATA_W-1:0] sad,
    output logic [CNT_W-1:0]  test_idx,
    input  logic [DATA_W-1:0] exp_x,
    input  logic [DATA_W-1:0] exp_y,
    input  logic [DATA_W-1:0] exp_sad,
    output logic              busy,
    output logic              done,
    output logic              last_match,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic              timeout
);

`ifdef VBSME_TIMEOUT_EN
    localparam int TMR_MAX = (RST_CYC > TIMEOUT_CYC) ? RST_CYC : TIMEOUT_CYC;
`else
    // Watchdog length plays no part here; the term only keeps it referenced.
    localparam int TMR_MAX = RST_CYC + 0 * TIMEOUT_CYC;
`endif
    localparam int TMR_W = $clog2(TMR_MAX + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_TESTS - 1);

    seq_state_t       state;
    result_t          res_q, exp_q;
    logic             match;
    logic             tmr_load, tmr_exp;
    logic [TMR_W-1:0] tmr_val;

    assign match = (res_q == exp_q);

    // One timer serves both the core-reset hold and the result watchdog;
    // it is reloaded on entry to whichever state is about to use it.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = TMR_W'(RST_CYC - 1);
        case (state)
            IDLE, DONE: tmr_load = start;
            NEXT:       tmr_load = (test_idx != LAST_IDX);
`ifdef VBSME_TIMEOUT_EN
            RST_CORE: begin
                tmr_load = tmr_exp;
                tmr_val  = TMR_W'(TIMEOUT_CYC - 1);
            end
`endif
            default: ;
        endcase
    end

    vbsme_cycle_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_exp)
    );

`ifdef VBSME_TIMEOUT_EN
    logic timeout_q;
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            core_rst   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            last_match <= 1'b0;
            test_idx   <= '0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            res_q      <= '0;
            exp_q      <= '0;
`ifdef VBSME_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= RST_CORE;
                        core_rst <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        test_idx <= '0;
                        pass_cnt <= '0;
                        fail_cnt <= '0;
`ifdef VBSME_TIMEOUT_EN
                        timeout_q <= 1'b0;
`endif
                    end
                end
                RST_CORE: begin
                    if (tmr_exp) begin
                        state    <= WAIT_RES;
                        core_rst <= 1'b0;
                    end
                end
                WAIT_RES: begin
                    // A strobe on the expiry cycle still takes the normal path.
                    if (res_valid) begin
                        res_q <= '{x: DEF_DATA_W'(x_sad), y: DEF_DATA_W'(y_sad),
                                   sad: DEF_DATA_W'(sad)};
                        exp_q <= '{x: DEF_DATA_W'(exp_x), y: DEF_DATA_W'(exp_y),
                                   sad: DEF_DATA_W'(exp_sad)};
                        state <= COMPARE;
                    end
`ifdef VBSME_TIMEOUT_EN
                    else if (tmr_exp) begin
                        if (fail_cnt != '1)
                            fail_cnt <= fail_cnt + 1'b1;
                        last_match <= 1'b0;
                        timeout_q  <= 1'b1;
                        state      <= NEXT;
                    end
`endif
                end
                COMPARE: begin
                    last_match <= match;
                    if (match) begin
                        if (pass_cnt != '1)
                            pass_cnt <= pass_cnt + 1'b1;
                    end else if (fail_cnt != '1) begin
                        fail_cnt <= fail_cnt + 1'b1;
                    end
                    state <= NEXT;
                end
                NEXT: begin
                    core_rst <= 1'b1;
                    if (test_idx == LAST_IDX) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        test_idx <= test_idx + 1'b1;
                        state    <= RST_CORE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vbsme_result_sequencer.sv
module tb_vbsme_result_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, res_valid;
    logic [31:0] x_sad, y_sad, sad, exp_x, exp_y, exp_sad;
    logic        core_rst, busy, done, last_match, timeout;
    logic [7:0]  test_idx, pass_cnt, fail_cnt;

    logic [31:0] exp_x_tab[4], exp_y_tab[4], exp_sad_tab[4];
    logic [31:0] core_x[4], core_y[4], core_sad[4];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    vbsme_result_sequencer #(
        .DATA_W(32), .NUM_TESTS(4), .RST_CYC(3), .TIMEOUT_CYC(16), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .core_rst(core_rst),
        .res_valid(res_valid), .x_sad(x_sad), .y_sad(y_sad), .sad(sad),
        .test_idx(test_idx), .exp_x(exp_x), .exp_y(exp_y), .exp_sad(exp_sad),
        .busy(busy), .done(done), .last_match(last_match),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .timeout(timeout)
    );

    // Expected-value table, presented combinationally from test_idx.
    always_comb begin
        exp_x   = exp_x_tab[test_idx[1:0]];
        exp_y   = exp_y_tab[test_idx[1:0]];
        exp_sad = exp_sad_tab[test_idx[1:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Fill expected table; core returns the same values unless corrupted.
    task automatic prep_tables(input bit rand_bad);
        for (int i = 0; i < 4; i++) begin
            exp_x_tab[i] = $urandom; exp_y_tab[i] = $urandom; exp_sad_tab[i] = $urandom;
            core_x[i] = exp_x_tab[i]; core_y[i] = exp_y_tab[i]; core_sad[i] = exp_sad_tab[i];
            if (rand_bad && $urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 2))
                    0:       core_x[i]   ^= (32'h1 << $urandom_range(0, 31));
                    1:       core_y[i]   ^= (32'h1 << $urandom_range(0, 31));
                    default: core_sad[i] ^= (32'h1 << $urandom_range(0, 31));
                endcase
            end
        end
    endtask

    function automatic bit model_match(input int t);
        return core_x[t] == exp_x_tab[t] && core_y[t] == exp_y_tab[t] &&
               core_sad[t] == exp_sad_tab[t];
    endfunction

    // Play one core trial. delay<0 picks a random result latency.
    task automatic do_trial(input int t, input bit noise, input bit in_wait,
                            input int delay, inout int mp, inout int mf);
        int n;
        int d;
        if (!in_wait) begin
            n = 0;
            while (core_rst !== 1'b1 && n < 20) begin tick(); n++; end
            if (noise) begin
                // start and a bogus strobe while the core is in reset
                start = 1'b1; res_valid = 1'b1;
                x_sad = ~core_x[t]; y_sad = ~core_y[t]; sad = ~core_sad[t];
                tick();
                start = 1'b0; res_valid = 1'b0;
            end
            n = 0;
            while (core_rst !== 1'b0 && n < 20) begin tick(); n++; end
            checks++;
            if (core_rst !== 1'b0) begin
                $display("FAIL trial%0d core_rst release: got %b want 0", t, core_rst);
                return;
            end else passes++;
        end
        d = (delay < 0) ? int'($urandom_range(0, 4)) : delay;
        repeat (d) tick();
        x_sad = core_x[t]; y_sad = core_y[t]; sad = core_sad[t];
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        x_sad = $urandom; y_sad = $urandom; sad = $urandom;
        tick();
        if (model_match(t)) mp++; else mf++;
        checks++; if (pass_cnt !== 8'(mp)) $display("FAIL trial%0d pass_cnt: got %0d want %0d", t, pass_cnt, mp); else passes++;
        checks++; if (fail_cnt !== 8'(mf)) $display("FAIL trial%0d fail_cnt: got %0d want %0d", t, fail_cnt, mf); else passes++;
        checks++; if (last_match !== model_match(t)) $display("FAIL trial%0d last_match: got %b want %b", t, last_match, model_match(t)); else passes++;
        checks++; if (test_idx !== 8'(t)) $display("FAIL trial%0d test_idx: got %0d want %0d", t, test_idx, t); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL trial%0d busy: got %b want 1", t, busy); else passes++;
    endtask

    task automatic check_done(input string tag, input int mp, input int mf, input bit lm);
        checks++; if (done !== 1'b1) $display("FAIL %s done: got %b want 1", tag, done); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL %s busy: got %b want 0", tag, busy); else passes++;
        checks++; if (core_rst !== 1'b1) $display("FAIL %s core_rst: got %b want 1", tag, core_rst); else passes++;
        checks++; if (pass_cnt !== 8'(mp)) $display("FAIL %s pass_cnt: got %0d want %0d", tag, pass_cnt, mp); else passes++;
        checks++; if (fail_cnt !== 8'(mf)) $display("FAIL %s fail_cnt: got %0d want %0d", tag, fail_cnt, mf); else passes++;
        checks++; if (last_match !== lm) $display("FAIL %s last_match: got %b want %b", tag, last_match, lm); else passes++;
    endtask

    task automatic run_all(input string tag, input bit noise);
        int mp = 0;
        int mf = 0;
        pulse_start();
        for (int t = 0; t < 4; t++) do_trial(t, noise && t == 1, 1'b0, -1, mp, mf);
        tick();
        check_done(tag, mp, mf, model_match(3));
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++; if (core_rst !== 1'b1) $display("FAIL reset core_rst: got %b want 1", core_rst); else passes++;
        checks++; if ({busy, done, last_match, timeout} !== 4'b0) $display("FAIL reset flags: got %b want 0000", {busy, done, last_match, timeout}); else passes++;
        checks++; if ({test_idx, pass_cnt, fail_cnt} !== 24'h0) $display("FAIL reset counters: got %h want 000000", {test_idx, pass_cnt, fail_cnt}); else passes++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_all_pass();
        prep_tables(1'b0);
        run_all("all_pass", 1'b0);
    endtask

    task automatic test_mismatch();
        prep_tables(1'b0);
        exp_sad_tab[2] = 32'h11;
        core_sad[2]    = 32'h10;
        run_all("mismatch", 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 3; r++) begin
            prep_tables(1'b1);
            run_all($sformatf("b2b%0d", r), 1'b0);
        end
    endtask

    // Restart from DONE with exact core_rst hold timing.
    task automatic test_restart_latency();
        int mp = 0;
        int mf = 0;
        prep_tables(1'b1);
        pulse_start();
        checks++; if ({busy, done} !== 2'b10) $display("FAIL restart busy/done: got %b want 10", {busy, done}); else passes++;
        checks++; if ({test_idx, pass_cnt, fail_cnt} !== 24'h0) $display("FAIL restart counters: got %h want 000000", {test_idx, pass_cnt, fail_cnt}); else passes++;
        for (int c = 1; c <= 3; c++) begin
            checks++; if (core_rst !== 1'b1) $display("FAIL latency core_rst t+%0d: got %b want 1", c, core_rst); else passes++;
            tick();
        end
        checks++; if (core_rst !== 1'b0) $display("FAIL latency core_rst t+4: got %b want 0", core_rst); else passes++;
        do_trial(0, 1'b0, 1'b1, -1, mp, mf);
        for (int t = 1; t < 4; t++) do_trial(t, 1'b0, 1'b0, -1, mp, mf);
        tick();
        check_done("restart", mp, mf, model_match(3));
    endtask

    task automatic test_start_reset();
        int mp = 0;
        int mf = 0;
        int n = 0;
        prep_tables(1'b1);
        pulse_start();
        do_trial(0, 1'b0, 1'b0, -1, mp, mf);
        do_trial(1, 1'b1, 1'b0, -1, mp, mf);
        while (core_rst !== 1'b1 && n < 20) begin tick(); n++; end
        n = 0;
        while (core_rst !== 1'b0 && n < 20) begin tick(); n++; end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if ({core_rst, busy, done, last_match, timeout} !== 5'b10000) $display("FAIL midreset flags: got %b want 10000", {core_rst, busy, done, last_match, timeout}); else passes++;
        checks++; if ({test_idx, pass_cnt, fail_cnt} !== 24'h0) $display("FAIL midreset counters: got %h want 000000", {test_idx, pass_cnt, fail_cnt}); else passes++;
        res_valid = 1'b1;
        repeat (4) tick();
        res_valid = 1'b0;
        checks++; if ({core_rst, busy, done, pass_cnt, fail_cnt} !== 19'h40000) $display("FAIL idle hold: got %h want 40000", {core_rst, busy, done, pass_cnt, fail_cnt}); else passes++;
    endtask

`ifdef VBSME_TIMEOUT_EN
    task automatic test_timeout();
        int mp = 0;
        int mf = 0;
        int n = 0;
        prep_tables(1'b0);
        pulse_start();
        while (core_rst !== 1'b0 && n < 20) begin tick(); n++; end
        repeat (15) tick();
        checks++; if ({fail_cnt, timeout} !== 9'h0) $display("FAIL wd early: got %h want 000", {fail_cnt, timeout}); else passes++;
        tick();
        checks++; if ({fail_cnt, timeout, last_match} !== 10'b0000000110) $display("FAIL wd expire: got %b want 0000000110", {fail_cnt, timeout, last_match}); else passes++;
        mf = 1;
        for (int t = 1; t < 4; t++) do_trial(t, 1'b0, 1'b0, -1, mp, mf);
        tick();
        check_done("wd_run", mp, mf, 1'b1);
        checks++; if (timeout !== 1'b1) $display("FAIL wd sticky: got %b want 1", timeout); else passes++;
        prep_tables(1'b0);
        mp = 0; mf = 0;
        pulse_start();
        do_trial(0, 1'b0, 1'b0, 15, mp, mf);
        checks++; if (timeout !== 1'b0) $display("FAIL wd edge win: got %b want 0", timeout); else passes++;
        for (int t = 1; t < 4; t++) do_trial(t, 1'b0, 1'b0, -1, mp, mf);
        tick();
        check_done("wd_edge", mp, mf, 1'b1);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1; start = 1'b0; res_valid = 1'b0;
        x_sad = '0; y_sad = '0; sad = '0;
        for (int i = 0; i < 4; i++) begin
            exp_x_tab[i] = '0; exp_y_tab[i] = '0; exp_sad_tab[i] = '0;
            core_x[i] = '0; core_y[i] = '0; core_sad[i] = '0;
        end
        test_reset();
        test_all_pass();
        test_mismatch();
        test_back_to_back();
        test_restart_latency();
        test_start_reset();
`ifdef VBSME_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
